// File: rtl/gpu_layer_pkg.sv
// Shared types for the layer fetch sequencer.
//  fetch_state_t : sequencer FSM states
//  layer_desc_t  : per-line fetch descriptor latched at grant time
//  LAYER_AW      : native layer-RAM address width
package gpu_layer_pkg;

  localparam int LAYER_AW = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    CALC  = 3'd2,
    ISSUE = 3'd3,
    DONE  = 3'd4
  } fetch_state_t;

  typedef struct packed {
    logic [LAYER_AW-1:0] start;
    logic                is_sprite;
    logic [7:0]          frame;
    logic [15:0]         height;
    logic [15:0]         width;
    logic [15:0]         y;
    logic [15:0]         x_start;
    logic [15:0]         count;
  } layer_desc_t;

endpackage

// File: rtl/layer_addr_gen.sv
// Registered address generator for one word of a layer line.
//  clk, reset : clock, async active-high reset
//  calc       : load enable, address for idx is registered when high
//  desc       : latched descriptor of the granted layer
//  idx        : word index within the line
//  frame_off  : frame*height*width, precomputed once per grant
//  addr       : registered read address (held while calc is low)
module layer_addr_gen
  import gpu_layer_pkg::*;
#(
  parameter int AW = LAYER_AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             calc,
  input  layer_desc_t      desc,
  input  logic [15:0]      idx,
  input  logic [AW-1:0]    frame_off,
  output logic [AW-1:0]    addr
);

  logic [16:0]   sprite_x;
  logic [15:0]   text_idx;
  logic [AW-1:0] row_off;
  logic [AW-1:0] next_addr;
  logic          unused_fields;

  // frame and height reach this block only through frame_off; count is used by the sequencer
  assign unused_fields = ^{desc.frame, desc.height, desc.count};

  // Address of word idx: sprite x keeps its carry (17 bits), text index wraps at 16 bits
  always_comb begin
    sprite_x = {1'b0, desc.x_start} + {1'b0, idx};
    text_idx = desc.x_start + idx;
    row_off  = AW'(desc.y) * AW'(desc.width);
    if (desc.is_sprite) begin
      next_addr = AW'(desc.start) + frame_off + row_off + AW'(sprite_x);
    end else begin
      next_addr = AW'(desc.start) + (AW'(text_idx) << 1);
    end
  end

  // Address register, updated only in the calculation cycle so it stays stable while issuing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr <= '0;
    end else if (calc) begin
      addr <= next_addr;
    end else begin
      addr <= addr;
    end
  end

endmodule

// File: rtl/layer_fetch_sequencer.sv
// Round-robin line-fetch sequencer between per-layer line buffers and the layer-RAM read port.
// A granted layer's descriptor is latched, then each word gets one CALC cycle (address
// registered) and one or more ISSUE cycles (request held until mem_ready).
//  clk, reset              : clock, async active-high reset
//  req[N]                  : level line request per layer, held until done
//  start_addr..count       : flat per-layer descriptor buses, slice i = layer i
//  mem_valid/mem_ready     : read request handshake
//  mem_addr/layer/last     : request address, layer tag, last word of line
//  done[N]                 : one-cycle pulse when a layer's line is fully issued
//  busy                    : sequencer not idle
module layer_fetch_sequencer
  import gpu_layer_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int AW         = LAYER_AW
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_LAYERS-1:0]           req,
  input  logic [AW*NUM_LAYERS-1:0]        start_addr,
  input  logic [NUM_LAYERS-1:0]           is_sprite,
  input  logic [8*NUM_LAYERS-1:0]         frame,
  input  logic [16*NUM_LAYERS-1:0]        height,
  input  logic [16*NUM_LAYERS-1:0]        width,
  input  logic [16*NUM_LAYERS-1:0]        y_line,
  input  logic [16*NUM_LAYERS-1:0]        x_start,
  input  logic [16*NUM_LAYERS-1:0]        count,
  output logic                            mem_valid,
  input  logic                            mem_ready,
  output logic [AW-1:0]                   mem_addr,
  output logic [$clog2(NUM_LAYERS)-1:0]   mem_layer,
  output logic                            mem_last,
  output logic [NUM_LAYERS-1:0]           done,
  output logic                            busy
);

  localparam int LW = $clog2(NUM_LAYERS);

  fetch_state_t  state;
  logic [LW-1:0] rr_ptr;
  logic [LW-1:0] grant;
  logic [LW-1:0] sel;
  logic          sel_found;
  layer_desc_t   desc;
  layer_desc_t   sel_desc;
  logic [AW-1:0] frame_off;
  logic [AW-1:0] sel_frame_off;
  logic [15:0]   idx;
  logic          idx_last;
  logic          calc;

  // Round-robin pick: scan from farthest to nearest so the first set request at/after rr_ptr wins
  always_comb begin
    sel_found = 1'b0;
    sel       = '0;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      sel_found = sel_found | req[(int'(rr_ptr) + k) % NUM_LAYERS];
      sel       = req[(int'(rr_ptr) + k) % NUM_LAYERS] ?
                  LW'((int'(rr_ptr) + k) % NUM_LAYERS) : sel;
    end
  end

  // Slice the selected layer's descriptor out of the flat buses and form its frame offset
  always_comb begin
    sel_desc.start     = LAYER_AW'(start_addr[int'(sel)*AW +: AW]);
    sel_desc.is_sprite = is_sprite[sel];
    sel_desc.frame     = frame[int'(sel)*8 +: 8];
    sel_desc.height    = height[int'(sel)*16 +: 16];
    sel_desc.width     = width[int'(sel)*16 +: 16];
    sel_desc.y         = y_line[int'(sel)*16 +: 16];
    sel_desc.x_start   = x_start[int'(sel)*16 +: 16];
    sel_desc.count     = count[int'(sel)*16 +: 16];
    sel_frame_off      = AW'(sel_desc.frame) * AW'(sel_desc.height) * AW'(sel_desc.width);
  end

  assign idx_last = (idx == (desc.count - 16'd1));
  assign calc     = (state == CALC);

  layer_addr_gen #(
    .AW(AW)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .calc      (calc),
    .desc      (desc),
    .idx       (idx),
    .frame_off (frame_off),
    .addr      (mem_addr)
  );

  // Sequencer FSM with arbiter pointer, word counter and all registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      desc      <= '0;
      frame_off <= '0;
      idx       <= 16'd0;
      mem_valid <= 1'b0;
      mem_layer <= '0;
      mem_last  <= 1'b0;
      done      <= '0;
      busy      <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            state <= GRANT;
            busy  <= 1'b1;
          end
        end
        GRANT: begin
          // a request dropped between IDLE and GRANT leaves nothing to serve
          if (sel_found) begin
            grant     <= sel;
            desc      <= sel_desc;
            frame_off <= sel_frame_off;
            idx       <= 16'd0;
            if (sel_desc.count == 16'd0) begin
              state     <= DONE;
              done[sel] <= 1'b1;
            end else begin
              state <= CALC;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        CALC: begin
          mem_valid <= 1'b1;
          mem_layer <= grant;
          mem_last  <= idx_last;
          state     <= ISSUE;
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (idx_last) begin
              state       <= DONE;
              done[grant] <= 1'b1;
            end else begin
              idx   <= idx + 16'd1;
              state <= CALC;
            end
          end
        end
        DONE: begin
          rr_ptr <= (grant == LW'(NUM_LAYERS - 1)) ? '0 : grant + LW'(1);
          state  <= IDLE;
          busy   <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          mem_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
